// File: rtl/kamacore_pkg.sv
// kamacore_pkg: shared width, ALU opcodes and control bundle for the kamacore pipeline
package kamacore_pkg;
  localparam int CPU_WIDTH = 32;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;
  typedef struct packed {
    alu_op_t alu_op;
    logic    alu_src_imm;
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
  } control_signals_t;
  function automatic logic is_multicycle(alu_op_t op);
    return op inside {ALU_MUL, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction
endpackage

// File: rtl/kamacore_pipeline_stage.sv
// kamacore_pipeline_stage: pipeline buffer contents passed between stages
interface kamacore_pipeline_stage;
  import kamacore_pkg::*;
  logic [31:0]          instruction;
  control_signals_t     control_signals;
  logic [CPU_WIDTH-1:0] source1;
  logic [CPU_WIDTH-1:0] source2;
  logic [CPU_WIDTH-1:0] immediate;
  logic [CPU_WIDTH-1:0] alu_result;
  modport producer(output instruction, control_signals, alu_result);
  modport consumer(input instruction, control_signals, source1, source2, immediate);
endinterface

// File: rtl/kamacore_muldiv_iter.sv
// kamacore_muldiv_iter: bit-serial multiplier / restoring divider with fixed latency
module kamacore_muldiv_iter
  import kamacore_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  alu_op_t              op,
  input  logic [CPU_WIDTH-1:0] a,
  input  logic [CPU_WIDTH-1:0] b,
  input  logic                 flush,
  output logic                 busy,
  output logic                 done,
  output logic [CPU_WIDTH-1:0] result
);
  localparam int CW = $clog2(CPU_WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t               state, state_nx;
  logic [CW-1:0]        cnt;
  logic [CPU_WIDTH-1:0] hi, lo, d, a_abs, b_abs;
  logic [CPU_WIDTH:0]   trial;
  alu_op_t              op_r;
  logic                 neg_q, neg_r, div0, sgn, launch;
  assign sgn    = op == ALU_DIV || op == ALU_REM;
  assign a_abs  = (sgn && a[CPU_WIDTH-1]) ? -a : a;
  assign b_abs  = (sgn && b[CPU_WIDTH-1]) ? -b : b;
  assign launch = state == IDLE && start && !flush;
  // hi stays below d for a non-zero divisor, so bit CPU_WIDTH of trial is the borrow
  assign trial  = {hi, lo[CPU_WIDTH-1]} - {1'b0, d};
  always_comb begin
    state_nx = flush ? IDLE
             : state == IDLE ? (start ? RUN : IDLE)
             : state == RUN  ? (cnt == CW'(CPU_WIDTH-1) ? DONE : RUN)
             : IDLE;
    busy     = rst && !flush && ((state == IDLE && start) || state == RUN);
    done     = state == DONE;
    result   = op_r == ALU_MUL ? hi
             : (op_r == ALU_DIV || op_r == ALU_DIVU) ? (div0 ? '1 : neg_q ? -lo : lo)
             : (neg_r ? -hi : hi);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
      d     <= '0;
      op_r  <= ALU_ADD;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      div0  <= 1'b0;
    end else begin
      state <= state_nx;
      if (launch) begin
        cnt   <= '0;
        op_r  <= op;
        hi    <= '0;
        lo    <= op == ALU_MUL ? b : a_abs;
        d     <= op == ALU_MUL ? a : b_abs;
        neg_q <= sgn && (a[CPU_WIDTH-1] ^ b[CPU_WIDTH-1]);
        neg_r <= sgn && a[CPU_WIDTH-1];
        div0  <= b == '0;
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        if (op_r == ALU_MUL) begin
          hi <= lo[0] ? hi + d : hi;
          d  <= d << 1;
          lo <= lo >> 1;
        end else begin
          hi <= trial[CPU_WIDTH] ? {hi[CPU_WIDTH-2:0], lo[CPU_WIDTH-1]} : trial[CPU_WIDTH-1:0];
          lo <= {lo[CPU_WIDTH-2:0], ~trial[CPU_WIDTH]};
        end
      end
    end
endmodule

// File: rtl/kamacore_stage_ex.sv
// kamacore_stage_ex: execute stage with single-cycle ALU and optional iterative mul/div
module kamacore_stage_ex
  import kamacore_pkg::*;
#(
  parameter bit MULDIV_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  kamacore_pipeline_stage.consumer pipeline_id_ex,
  kamacore_pipeline_stage.producer pipeline_ex_mem,
  input  logic                     flush,
  output logic                     stall
);
  localparam int SH = $clog2(CPU_WIDTH);
  control_signals_t     ctrl;
  logic [CPU_WIDTH-1:0] a, b, alu, md_result;
  logic [SH-1:0]        sh;
  logic                 mc_op, md_done;
  assign ctrl  = pipeline_id_ex.control_signals;
  assign a     = pipeline_id_ex.source1;
  assign b     = ctrl.alu_src_imm ? pipeline_id_ex.immediate : pipeline_id_ex.source2;
  assign sh    = b[SH-1:0];
  assign mc_op = is_multicycle(ctrl.alu_op);
  always_comb begin
    alu = '0;
    case (ctrl.alu_op)
      ALU_ADD:  alu = a + b;
      ALU_SUB:  alu = a - b;
      ALU_AND:  alu = a & b;
      ALU_OR:   alu = a | b;
      ALU_XOR:  alu = a ^ b;
      ALU_SLL:  alu = a << sh;
      ALU_SRL:  alu = a >> sh;
      ALU_SRA:  alu = $signed(a) >>> sh;
      ALU_SLT:  alu = {{(CPU_WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: alu = {{(CPU_WIDTH-1){1'b0}}, a < b};
      default:  alu = '0;
    endcase
  end
  if (MULDIV_EN) begin : g_md
    kamacore_muldiv_iter u_md (
      .clk    (clk),
      .rst    (rst),
      .start  (mc_op),
      .op     (ctrl.alu_op),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .busy   (stall),
      .done   (md_done),
      .result (md_result)
    );
  end else begin : g_no_md
    assign stall     = 1'b0;
    assign md_done   = 1'b1;
    assign md_result = '0;
  end
  // a multi-cycle op sends bubbles until its result is ready
  always_ff @(posedge clk or negedge rst)
    if (!rst || flush || (mc_op && !md_done)) begin
      pipeline_ex_mem.alu_result      <= '0;
      pipeline_ex_mem.instruction     <= '0;
      pipeline_ex_mem.control_signals <= '0;
    end else begin
      pipeline_ex_mem.alu_result      <= mc_op ? md_result : alu;
      pipeline_ex_mem.instruction     <= pipeline_id_ex.instruction;
      pipeline_ex_mem.control_signals <= ctrl;
    end
endmodule

// File: tb/tb_kamacore_stage_ex.sv
// tb_kamacore_stage_ex: directed vectors for the execute stage
module tb_kamacore_stage_ex;
  import kamacore_pkg::*;
  logic clk, rst, flush, stall;
  int   checks, errors;
  kamacore_pipeline_stage id_ex ();
  kamacore_pipeline_stage ex_mem ();
  kamacore_stage_ex dut (
    .clk             (clk),
    .rst             (rst),
    .pipeline_id_ex  (id_ex),
    .pipeline_ex_mem (ex_mem),
    .flush           (flush),
    .stall           (stall)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic drive(input alu_op_t op, input logic [31:0] s1, input logic [31:0] s2,
                       input logic [31:0] imm, input logic si, input logic [31:0] ins);
    id_ex.control_signals             = '0;
    id_ex.control_signals.alu_op      = op;
    id_ex.control_signals.alu_src_imm = si;
    id_ex.control_signals.reg_write   = 1'b1;
    id_ex.source1                     = s1;
    id_ex.source2                     = s2;
    id_ex.immediate                   = imm;
    id_ex.instruction                 = ins;
  endtask
  task automatic sc(input string tag, input alu_op_t op, input logic [31:0] s1,
                    input logic [31:0] s2, input logic [31:0] imm, input logic si,
                    input logic [31:0] exp);
    drive(op, s1, s2, imm, si, 32'h100 + 32'(op));
    #1;
    check({tag, "_stall"}, 32'(stall), 0);
    @(posedge clk);
    #1;
    check(tag, ex_mem.alu_result, exp);
  endtask
  task automatic run_mc(input string tag, input alu_op_t op, input logic [31:0] s1,
                        input logic [31:0] s2, input logic [31:0] exp, input logic [31:0] ins);
    int ns, nb;
    ns = 0;
    nb = 0;
    drive(op, s1, s2, 32'h0, 1'b0, ins);
    for (int e = 1; e <= 34; e++) begin
      #1;
      if (stall) ns++;
      @(posedge clk);
      #1;
      if (e < 34 && (ex_mem.alu_result != 0 || ex_mem.instruction != 0 || ex_mem.control_signals != 0))
        nb++;
    end
    check({tag, "_stall_cycles"}, 32'(ns), 33);
    check({tag, "_bubbles"}, 32'(nb), 0);
    check(tag, ex_mem.alu_result, exp);
    check({tag, "_instr"}, ex_mem.instruction, ins);
    drive(ALU_ADD, 0, 0, 0, 1'b0, 0);
  endtask
  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    flush  = 1'b0;
    drive(ALU_ADD, 0, 0, 0, 1'b0, 0);
    #2 rst = 1'b0;
    #1;
    check("rst_result", ex_mem.alu_result, 0);
    check("rst_instr", ex_mem.instruction, 0);
    check("rst_stall", 32'(stall), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    sc("add", ALU_ADD, 32'd5, 32'd7, 0, 1'b0, 32'd12);
    sc("sra", ALU_SRA, 32'h8000_0000, 32'd4, 0, 1'b0, 32'hF800_0000);
    sc("sub", ALU_SUB, 32'd5, 32'd7, 0, 1'b0, 32'hFFFF_FFFE);
    sc("slt", ALU_SLT, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 32'd1);
    sc("sltu", ALU_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, 32'd0);
    sc("sll_imm", ALU_SLL, 32'd3, 32'd9, 32'h21, 1'b1, 32'd6);
    sc("xor_imm", ALU_XOR, 32'hF0F0_F0F0, 32'd0, 32'hFF00_FF00, 1'b1, 32'h0FF0_0FF0);
    check("sc_ctrl_op", 32'(ex_mem.control_signals.alu_op), 32'(ALU_XOR));
    run_mc("mul", ALU_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 32'h0200_0033);
    run_mc("div_neg", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'h0200_4033);
    run_mc("rem_neg", ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'h0200_6033);
    run_mc("divu", ALU_DIVU, 32'd100, 32'd7, 32'd14, 32'h0200_5033);
    run_mc("divu_zero", ALU_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'h0200_5133);
    run_mc("remu_zero", ALU_REMU, 32'd9, 32'd0, 32'd9, 32'h0200_7133);
    run_mc("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0200_4133);
    run_mc("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h0200_6133);
    drive(ALU_DIV, 32'd100, 32'd7, 0, 1'b0, 32'h0200_4233);
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    #1;
    check("flush_stall", 32'(stall), 0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    check("flush_bubble_result", ex_mem.alu_result, 0);
    check("flush_bubble_instr", ex_mem.instruction, 0);
    sc("add_after_flush", ALU_ADD, 32'd1, 32'd2, 0, 1'b0, 32'd3);
    check("add_after_flush_instr", ex_mem.instruction, 32'h100);
    drive(ALU_DIVU, 32'd1000, 32'd3, 0, 1'b0, 32'h0200_5233);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    check("mid_run_stall", 32'(stall), 1);
    rst = 1'b0;
    #1;
    check("async_rst_stall", 32'(stall), 0);
    check("async_rst_result", ex_mem.alu_result, 0);
    check("async_rst_instr", ex_mem.instruction, 0);
    drive(ALU_MUL, 32'd6, 32'd7, 0, 1'b0, 32'h0200_0133);
    @(posedge clk);
    #1;
    check("rst_held_stall", 32'(stall), 0);
    rst = 1'b1;
    run_mc("mul_after_rst", ALU_MUL, 32'd6, 32'd7, 32'd42, 32'h0200_0133);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
